// File: rtl/mc_ctrl_fsm_irq_if.sv
// mc_ctrl_fsm_irq_if
// Groups the control unit's datapath-facing signals.
//   master : the control FSM (receives opcode/irq lines, drives selects,
//            enables, EPC strobe, grant pulse, vector ID and int_en).
//   slave  : the datapath / interrupt sources (opposite directions).
// Parameters: NUM_IRQ request lines, ID_W bits of vector ID.
interface mc_ctrl_fsm_irq_if #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
);
    logic [5:0]         opcode;
    logic [NUM_IRQ-1:0] irq_req;
    logic [NUM_IRQ-1:0] irq_mask;

    logic [1:0]         alu_op;
    logic [1:0]         alu_src_b;
    logic [1:0]         wreg_dst;
    logic [1:0]         wreg_data_sel;
    logic               mem_read;
    logic               mem_write;
    logic               i_or_d;
    logic               reg_write;
    logic               ir_write;
    logic               pc_write;
    logic               pc_write_cond;
    logic               alu_src_a;
    logic               imm_com;
    logic [2:0]         pc_source;
    logic               epc_write;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [ID_W-1:0]    irq_id;
    logic               int_en;

    modport master (
        input  opcode, irq_req, irq_mask,
        output alu_op, alu_src_b, wreg_dst, wreg_data_sel,
               mem_read, mem_write, i_or_d, reg_write, ir_write,
               pc_write, pc_write_cond, alu_src_a, imm_com, pc_source,
               epc_write, irq_ack, irq_id, int_en
    );

    modport slave (
        output opcode, irq_req, irq_mask,
        input  alu_op, alu_src_b, wreg_dst, wreg_data_sel,
               mem_read, mem_write, i_or_d, reg_write, ir_write,
               pc_write, pc_write_cond, alu_src_a, imm_com, pc_source,
               epc_write, irq_ack, irq_id, int_en
    );
endinterface

// File: rtl/mc_ctrl_fsm_irq.sv
// mc_ctrl_fsm_irq
// Multicycle MIPS-subset control FSM with vectored, maskable, fixed-priority
// interrupts (lowest index wins). Interrupts are sampled only in FETCH; a taken
// interrupt spends one INT_ENTER cycle saving EPC and loading the vector PC.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : master side of mc_ctrl_fsm_irq_if (opcode, irq_req, irq_mask in;
//              datapath selects/enables, epc_write, irq_ack, irq_id, int_en out)
module mc_ctrl_fsm_irq #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mc_ctrl_fsm_irq_if.master     bus
);
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_RFE   = 6'b010000;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM_WB, S_MEM_RD, S_INT_ENTER
    } state_e;

    state_e             state_q, state_d;
    logic               int_en_q, int_en_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [ID_W-1:0]    grant_q, grant_d;

    logic [NUM_IRQ-1:0] pending;
    logic               take;
    logic [ID_W-1:0]    low_idx;
    logic               is_itype;

    assign pending = bus.irq_req & ~bus.irq_mask;
    assign take    = int_en_q & (|pending);

    // Scan high to low so the last hit, i.e. the lowest set index, wins.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) low_idx = ID_W'(i);
        end
    end

    always_comb begin
        is_itype = 1'b0;
        case (bus.opcode)
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: is_itype = 1'b1;
            default:                                    is_itype = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        int_en_d = int_en_q;
        irq_id_d = irq_id_q;
        grant_d  = grant_q;

        bus.alu_op        = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.wreg_dst      = 2'b00;
        bus.wreg_data_sel = 2'b00;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.reg_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.imm_com       = 1'b0;
        bus.pc_source     = 3'd0;
        bus.epc_write     = 1'b0;
        bus.irq_ack       = '0;

        // Reset blanks every strobe, so a reset landing in INT_ENTER yields
        // neither an EPC save nor an acknowledge.
        if (!rst) begin
            // imm_com is a pure opcode decode, independent of state.
            bus.imm_com = is_itype;
            case (state_q)
                S_FETCH: begin
                    if (take) begin
                        grant_d = low_idx;
                        state_d = S_INT_ENTER;
                    end else begin
                        bus.ir_write  = 1'b1;
                        bus.mem_read  = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.alu_src_b = 2'b01;
                        state_d       = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_b = 2'b11;
                    state_d       = S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 2'b10;
                        state_d       = S_MEM_WB;
                    end else if (bus.opcode == OP_J || bus.opcode == OP_JAL) begin
                        bus.pc_write  = 1'b1;
                        bus.pc_source = 3'd2;
                        if (bus.opcode == OP_JAL) begin
                            bus.reg_write     = 1'b1;
                            bus.wreg_dst      = 2'b10;
                            bus.wreg_data_sel = 2'b10;
                        end
                    end else if (bus.opcode == OP_BEQ) begin
                        bus.pc_write_cond = 1'b1;
                        bus.pc_source     = 3'd1;
                        bus.alu_op        = 2'b01;
                        bus.alu_src_a     = 1'b1;
                    end else if (bus.opcode == OP_RTYPE) begin
                        bus.alu_op    = 2'b10;
                        bus.alu_src_a = 1'b1;
                        state_d       = S_MEM_WB;
                    end else if (is_itype) begin
                        bus.alu_op    = 2'b10;
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 2'b10;
                        state_d       = S_MEM_WB;
                    end else if (bus.opcode == OP_RFE) begin
                        bus.pc_write  = 1'b1;
                        bus.pc_source = 3'd4;
                        int_en_d      = 1'b1;
                    end
                end
                S_MEM_WB: begin
                    state_d = S_FETCH;
                    if (bus.opcode == OP_RTYPE) begin
                        bus.reg_write = 1'b1;
                        bus.wreg_dst  = 2'b01;
                    end else if (is_itype) begin
                        bus.reg_write = 1'b1;
                    end else if (bus.opcode == OP_LW) begin
                        bus.i_or_d   = 1'b1;
                        bus.mem_read = 1'b1;
                        state_d      = S_MEM_RD;
                    end else if (bus.opcode == OP_SW) begin
                        bus.i_or_d    = 1'b1;
                        bus.mem_write = 1'b1;
                    end
                end
                S_MEM_RD: begin
                    bus.reg_write     = 1'b1;
                    bus.wreg_data_sel = 2'b01;
                    state_d           = S_FETCH;
                end
                S_INT_ENTER: begin
                    bus.epc_write = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 3'd3;
                    bus.irq_ack   = NUM_IRQ'(1) << grant_q;
                    irq_id_d      = grant_q;
                    int_en_d      = 1'b0;
                    state_d       = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            int_en_q <= 1'b1;
            irq_id_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            int_en_q <= int_en_d;
            irq_id_q <= irq_id_d;
            grant_q  <= grant_d;
        end
    end

    assign bus.irq_id = irq_id_q;
    assign bus.int_en = int_en_q;
endmodule

// File: doc/mc_ctrl_fsm_irq.md
# mc_ctrl_fsm_irq

Multicycle MIPS-subset control FSM with vectored interrupt support for NUM_IRQ request lines. It sits between the instruction register opcode field and the datapath. It drives the same mux selects and write enables as the single-interrupt control unit. It adds per-line masking, fixed priority, a registered interrupt-enable flag, an EPC save strobe, a vector ID and one-hot acknowledge.

## Interface
- NUM_IRQ, 4: number of interrupt request lines (1..16).
- ID_W, $clog2(NUM_IRQ) (minimum 1): width of irq_id.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- opcode  in  6  IR[31:26]
- irq_req  in  NUM_IRQ  level-sensitive requests
- irq_mask  in  NUM_IRQ  1 = line masked
- alu_op, alu_src_b, wreg_dst, wreg_data_sel  out  2 each  datapath selects
- mem_read, mem_write, i_or_d, reg_write, ir_write, pc_write, pc_write_cond, alu_src_a, imm_com  out  1 each  enables/selects
- pc_source  out  3  0 ALU, 1 ALUOut, 2 jump target, 3 interrupt vector, 4 EPC
- epc_write  out  1  EPC <= PC this cycle
- irq_ack  out  NUM_IRQ  one-hot grant pulse
- irq_id  out  ID_W  registered ID of last granted line (vector index)
- int_en  out  1  registered global interrupt enable

## Operation
- Opcodes: LW 100011, SW 101011, BEQ 000100, RTYPE 000000, J 000010, JAL 000011, ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, RFE 010000.
- States: FETCH, DECODE, EXEC, MEM_WB, MEM_RD, INT_ENTER. Outputs are combinational from state and opcode. Every output not named for a state is 0; no X is ever driven.
- imm_com = 1 for ADDI/ANDI/ORI/XORI/SLTI in every state.
- pending = irq_req & ~irq_mask. take = int_en & |pending.
- FETCH, take=0:
  - ir_write=1, mem_read=1, i_or_d=0.
  - pc_write=1, pc_source=0, alu_op=00, alu_src_a=0, alu_src_b=01.
  - Next state DECODE.
- FETCH, take=1:
  - No outputs asserted; the instruction is not fetched.
  - Next state INT_ENTER. The granted line is the lowest set index of pending and is captured into an internal grant register.
- DECODE: alu_op=00, alu_src_a=0, alu_src_b=11. Next state EXEC.
- EXEC:
  - LW/SW: alu 00, a=1, b=10. Next state MEM_WB.
  - J: pc_write=1, pc_source=2. Next state FETCH.
  - JAL: as J, plus reg_write=1, wreg_dst=10, wreg_data_sel=10. Next state FETCH.
  - BEQ: pc_write_cond=1, pc_source=1, alu 01, a=1, b=00. Next state FETCH.
  - RTYPE: alu 10, a=1, b=00. Next state MEM_WB.
  - I-type: alu 10, a=1, b=10. Next state MEM_WB.
  - RFE: pc_write=1, pc_source=4; int_en <= 1 at the clock edge. Next state FETCH.
  - Other opcodes: no outputs. Next state FETCH.
- MEM_WB:
  - RTYPE: reg_write=1, wreg_dst=01, wreg_data_sel=00. Next state FETCH.
  - I-type: reg_write=1, wreg_dst=00, wreg_data_sel=00. Next state FETCH.
  - LW: i_or_d=1, mem_read=1. Next state MEM_RD.
  - SW: i_or_d=1, mem_write=1. Next state FETCH.
- MEM_RD: reg_write=1, wreg_dst=00, wreg_data_sel=01. Next state FETCH.
- INT_ENTER:
  - epc_write=1, pc_write=1, pc_source=3.
  - irq_ack = one-hot of the grant register.
  - At the edge: irq_id <= grant index and int_en <= 0. Next state FETCH.
- int_en, irq_id, grant register and state are the only registers. int_en changes only on RFE, INT_ENTER and reset.

## Timing
- Reset: state <= FETCH, int_en <= 1, irq_id <= 0, grant <= 0. While rst=1, every output except int_en and irq_id is forced to 0.
- Cycles per instruction:
  - BEQ, J, JAL, RFE, illegal opcode: 3.
  - RTYPE, I-type, SW: 4.
  - LW: 5.
- Interrupt entry costs 1 cycle (INT_ENTER). The vector fetch follows immediately in FETCH.
- Interrupts are sampled only in FETCH. A request that rises and falls entirely within non-FETCH cycles is lost; sources must hold the request until they see irq_ack.
- Simultaneous unmasked requests: the lowest index wins. Others stay pending for the next FETCH.
- Masking change: irq_mask is sampled combinationally in FETCH only.
- Nesting:
  - int_en=0 from the cycle after INT_ENTER until the cycle after RFE EXEC. Requests arriving in that window are ignored until then.
  - A request still pending at the first FETCH after RFE is taken, so back-to-back handlers are legal.
- rst during INT_ENTER: epc_write and irq_ack are suppressed, no grant occurs, and int_en returns to 1.

## Test plan
- Reset, then ADDI stream, irq_req=0 -> FETCH/DECODE/EXEC/MEM_WB repeat every 4 cycles; reg_write=1, wreg_dst=00 in MEM_WB; int_en=1, irq_id=0.
- LW, then BEQ -> LW occupies 5 cycles with mem_read=1, i_or_d=1 in MEM_WB; BEQ occupies 3 cycles with pc_write_cond=1, pc_source=1 in EXEC.
- NUM_IRQ=4, irq_req=0110, mask=0000 during RTYPE EXEC -> next FETCH goes to INT_ENTER without ir_write; irq_ack=0010, epc_write=1, pc_source=3; then irq_id=1, int_en=0.
- With int_en=0, irq_req=1000 held, run RFE -> EXEC shows pc_source=4, pc_write=1; int_en=1 the next cycle; that FETCH enters INT_ENTER with irq_ack=1000, irq_id=3.
- irq_req=0001, mask=0001 -> never taken. Clear the mask -> taken at the next FETCH.
- rst asserted in INT_ENTER -> no irq_ack or epc_write pulse; state=FETCH, int_en=1, irq_id=0 after the edge.
